// File: rtl/hsv_core_issue_scheduler.sv
// Issue-stage scheduler: one held decoded entry, register scoreboard, one-hot unit dispatch.
// Optional build macro HSV_ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
package hsv_issue_pkg;
   typedef logic [4:0] reg_addr_t;
   typedef logic [3:0] exec_sel_t;

   localparam exec_sel_t SELECT_ALU    = 4'b0001;
   localparam exec_sel_t SELECT_BRANCH = 4'b0010;
   localparam exec_sel_t SELECT_MEM    = 4'b0100;
   localparam exec_sel_t SELECT_CSR    = 4'b1000;

   typedef struct packed {
      reg_addr_t   rs1;
      reg_addr_t   rs2;
      reg_addr_t   rd;
      exec_sel_t   exec_select;
      logic [15:0] payload;
   } issue_data_t;
endpackage

module hsv_core_issue_scheduler
   import hsv_issue_pkg::*;
#(
   parameter bit SerializeCsr = 1'b1
) (
   input  logic        clk_core,
   input  logic        rst_core,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  issue_data_t in_data,
   output issue_data_t out_data,
   output logic        alu_valid,
   input  logic        alu_ready,
   output logic        branch_valid,
   input  logic        branch_ready,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        csr_valid,
   input  logic        csr_ready,
   input  logic        wb_valid,
   input  reg_addr_t   wb_rd,
   output logic        idle
);

   // Only EMPTY/HELD is stored; STALL and SEND are the hazard-dependent views of HELD.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   issue_data_t data_q, data_d;
   logic [31:0] busy_q, busy_d;
   logic [31:0] wb_clr_s, busy_eff_s, busy_set_s;
   logic [3:0]  route_s, ready_s;
   logic        held_s, csr_block_s, hazard_s, send_s;
   logic        unit_ready_s, dispatch_s, accept_s;

   function automatic logic addr_busy(input logic [31:0] mask, input reg_addr_t addr);
      return (addr != 5'd0) && mask[addr];
   endfunction

   // Writeback clear mask; x0 is never tracked.
   always_comb begin
      wb_clr_s = 32'd0;
      if (wb_valid && (wb_rd != 5'd0)) begin
         wb_clr_s[wb_rd] = 1'b1;
      end else begin
         wb_clr_s = 32'd0;
      end
   end

`ifdef HSV_ISSUE_WB_BYPASS_EN
   assign busy_eff_s = busy_q & ~wb_clr_s;
`else
   assign busy_eff_s = busy_q;
`endif

   assign held_s      = (state_q == ST_HELD);
   assign csr_block_s = SerializeCsr && (data_q.exec_select == SELECT_CSR) && (busy_eff_s != 32'd0);
   assign hazard_s    = addr_busy(busy_eff_s, data_q.rs1) | addr_busy(busy_eff_s, data_q.rs2) |
                        addr_busy(busy_eff_s, data_q.rd)  | csr_block_s;
   assign send_s      = held_s & ~hazard_s & ~rst_core & ~flush;

   // Unit routing; anything not strictly one-hot falls back to the ALU.
   always_comb begin
      case (data_q.exec_select)
         SELECT_ALU:    route_s = 4'b0001;
         SELECT_BRANCH: route_s = 4'b0010;
         SELECT_MEM:    route_s = 4'b0100;
         SELECT_CSR:    route_s = 4'b1000;
         default:       route_s = 4'b0001;
      endcase
   end

   assign ready_s      = {csr_ready, mem_ready, branch_ready, alu_ready};
   assign unit_ready_s = |(route_s & ready_s);
   assign dispatch_s   = send_s & unit_ready_s;
   assign in_ready     = ~rst_core & ~flush & (~held_s | dispatch_s);
   assign accept_s     = in_valid & in_ready;

   assign alu_valid    = send_s & route_s[0];
   assign branch_valid = send_s & route_s[1];
   assign mem_valid    = send_s & route_s[2];
   assign csr_valid    = send_s & route_s[3];
   assign out_data     = data_q;
   assign idle         = ~held_s & (busy_q == 32'd0);

   // Scoreboard set on dispatch; a same-cycle set beats the writeback clear.
   always_comb begin
      busy_set_s = 32'd0;
      if (dispatch_s && (data_q.rd != 5'd0)) begin
         busy_set_s[data_q.rd] = 1'b1;
      end else begin
         busy_set_s = 32'd0;
      end
      busy_d = (busy_q & ~wb_clr_s) | busy_set_s;
   end

   // Entry hold/release: a new accept may replace an entry dispatching this cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (accept_s) begin
         state_d = ST_HELD;
         data_d  = in_data;
      end else if (dispatch_s) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // State registers; flush drops the entry and scoreboard but keeps the data word.
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_q <= ST_EMPTY;
         busy_q  <= 32'd0;
         data_q  <= '0;
      end else if (flush) begin
         state_q <= ST_EMPTY;
         busy_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_hsv_core_issue_scheduler.sv
// Self-checking bench for hsv_core_issue_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a behavioural scoreboard model.
module tb_hsv_core_issue_scheduler;
   import hsv_issue_pkg::*;

   localparam bit SERIALIZE = 1'b1;

   logic        clk_core = 1'b0;
   logic        rst_core = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   issue_data_t in_data = '0;
   issue_data_t out_data;
   logic        alu_valid, branch_valid, mem_valid, csr_valid;
   logic [3:0]  rdy = 4'b0000;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic        idle;

   int checks = 0;
   int failures = 0;

   // Model state: held entry and per-register busy flags.
   bit          m_held = 1'b0;
   issue_data_t m_ent = '0;
   bit          m_busy[32];
   bit          m_fire;
   bit          m_in_ready;
   logic [5:0]  exp_flags;
   issue_data_t exp_data;
   logic [5:0]  obs_flags;

   assign obs_flags = {alu_valid, branch_valid, mem_valid, csr_valid, in_ready, idle};

   hsv_core_issue_scheduler #(.SerializeCsr(SERIALIZE)) dut (
      .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_data(out_data),
      .alu_valid(alu_valid), .alu_ready(rdy[0]),
      .branch_valid(branch_valid), .branch_ready(rdy[1]),
      .mem_valid(mem_valid), .mem_ready(rdy[2]),
      .csr_valid(csr_valid), .csr_ready(rdy[3]),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .idle(idle)
   );

   always #5 clk_core = ~clk_core;

   function automatic issue_data_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [3:0] sel);
      issue_data_t d;
      d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.exec_select = sel;
      d.payload = 16'($urandom);
      return d;
   endfunction

   task automatic drive(input bit v, input issue_data_t d, input logic [3:0] r,
                        input bit wbv, input logic [4:0] wbr, input bit fl);
      in_valid = v; in_data = d; rdy = r; wb_valid = wbv; wb_rd = wbr; flush = fl;
   endtask

   // Expected outputs for the current inputs, from the scheduling rules.
   task automatic model_eval();
      bit eff[32];
      bit blocked, any, offer;
      int unit;
      eff = m_busy;
`ifdef HSV_ISSUE_WB_BYPASS_EN
      if (wb_valid && wb_rd != 5'd0) eff[wb_rd] = 1'b0;
`endif
      blocked = (m_ent.rs1 != 0 && eff[m_ent.rs1]) || (m_ent.rs2 != 0 && eff[m_ent.rs2]) ||
                (m_ent.rd != 0 && eff[m_ent.rd]);
      any = 1'b0;
      for (int i = 1; i < 32; i++) any |= eff[i];
      if (SERIALIZE && m_ent.exec_select == 4'b1000 && any) blocked = 1'b1;
      case (m_ent.exec_select)
         4'b0010: unit = 1;
         4'b0100: unit = 2;
         4'b1000: unit = 3;
         default: unit = 0;
      endcase
      offer = m_held && !blocked && !flush && !rst_core;
      m_fire = offer && rdy[unit];
      m_in_ready = !rst_core && !flush && (!m_held || m_fire);
      any = 1'b0;
      for (int i = 0; i < 32; i++) any |= m_busy[i];
      exp_flags = {offer && unit == 0, offer && unit == 1, offer && unit == 2, offer && unit == 3,
                   m_in_ready, !m_held && !any};
      exp_data = m_ent;
   endtask

   task automatic model_commit();
      if (rst_core) begin
         m_held = 1'b0; m_ent = '0;
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (flush) begin
         m_held = 1'b0;
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         if (wb_valid && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
         if (m_fire && m_ent.rd != 5'd0) m_busy[m_ent.rd] = 1'b1;
         if (in_valid && m_in_ready) begin
            m_held = 1'b1; m_ent = in_data;
         end else if (m_fire) begin
            m_held = 1'b0;
         end
      end
   endtask

   task automatic settle();
      #4;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk_core);
      model_commit();
      #1;
   endtask

   task automatic clear_state();
      drive(1'b0, '0, 4'b0000, 1'b0, 5'd0, 1'b1);
      settle();
      tick();
   endtask

   task automatic test_reset();
      rst_core = 1'b1;
      drive(1'b1, mk(5'd1, 5'd2, 5'd3, SELECT_ALU), 4'b1111, 1'b0, 5'd0, 1'b0);
      settle();
      tick();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) rst_core = 1'b0;
         if (c == 2) in_valid = 1'b0;
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL reset_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL reset_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_independent();
      clear_state();
      for (int c = 0; c < 10; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd2, 5'd3, 5'd1, SELECT_ALU), 4'b0001, 1'b0, 5'd0, 1'b0);
            1: drive(1'b1, mk(5'd5, 5'd6, 5'd4, SELECT_ALU), 4'b0001, 1'b0, 5'd0, 1'b0);
            3: drive(1'b1, mk(5'd1, 5'd4, 5'd9, SELECT_ALU), 4'b0001, 1'b0, 5'd0, 1'b0);
            5: drive(1'b0, '0, 4'b0001, 1'b1, 5'd1, 1'b0);
            6: drive(1'b0, '0, 4'b0001, 1'b1, 5'd4, 1'b0);
            8: drive(1'b0, '0, 4'b0001, 1'b1, 5'd9, 1'b0);
            default: drive(1'b0, '0, 4'b0001, 1'b0, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL indep_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL indep_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_dependent();
      clear_state();
      for (int c = 0; c < 10; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd2, 5'd0, 5'd1, SELECT_ALU), 4'b0001, 1'b0, 5'd0, 1'b0);
            1: drive(1'b1, mk(5'd1, 5'd0, 5'd3, SELECT_ALU), 4'b0001, 1'b0, 5'd0, 1'b0);
            5: drive(1'b0, '0, 4'b0001, 1'b1, 5'd1, 1'b0);
            8: drive(1'b0, '0, 4'b0001, 1'b1, 5'd3, 1'b0);
            default: drive(1'b0, '0, 4'b0001, 1'b0, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL dep_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL dep_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      issue_data_t nxt;
      clear_state();
      nxt = mk(5'd0, 5'd0, 5'd0, SELECT_BRANCH);
      for (int c = 0; c < 7; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd3, 5'd4, 5'd0, SELECT_MEM), 4'b0000, 1'b0, 5'd0, 1'b0);
            1, 2, 3: drive(1'b1, nxt, 4'b1011, 1'b0, 5'd0, 1'b0);
            4: drive(1'b1, nxt, 4'b0100, 1'b0, 5'd0, 1'b0);
            5: drive(1'b0, '0, 4'b0010, 1'b0, 5'd0, 1'b0);
            default: drive(1'b0, '0, 4'b0000, 1'b0, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL bp_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL bp_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_csr_serialize();
      clear_state();
      for (int c = 0; c < 9; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd1, 5'd2, 5'd7, SELECT_ALU), 4'b1001, 1'b0, 5'd0, 1'b0);
            1: drive(1'b1, mk(5'd0, 5'd0, 5'd0, SELECT_CSR), 4'b1001, 1'b0, 5'd0, 1'b0);
            5: drive(1'b0, '0, 4'b1111, 1'b1, 5'd7, 1'b0);
            default: drive(1'b0, '0, 4'b1111, 1'b0, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL csr_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL csr_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      clear_state();
      for (int c = 0; c < 7; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd0, 5'd0, 5'd1, SELECT_ALU), 4'b0011, 1'b0, 5'd0, 1'b0);
            1: drive(1'b1, mk(5'd0, 5'd0, 5'd2, SELECT_BRANCH), 4'b0011, 1'b0, 5'd0, 1'b0);
            2: drive(1'b1, mk(5'd3, 5'd4, 5'd5, SELECT_MEM), 4'b0011, 1'b0, 5'd0, 1'b0);
            4: drive(1'b1, mk(5'd6, 5'd0, 5'd8, SELECT_ALU), 4'b1111, 1'b1, 5'd1, 1'b1);
            default: drive(1'b0, '0, 4'b0000, 1'b0, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL flush_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL flush_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_x0();
      clear_state();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: drive(1'b1, mk(5'd0, 5'd0, 5'd0, SELECT_ALU), 4'b0000, 1'b1, 5'd0, 1'b0);
            1: drive(1'b0, '0, 4'b0001, 1'b1, 5'd0, 1'b0);
            default: drive(1'b0, '0, 4'b0000, 1'b1, 5'd0, 1'b0);
         endcase
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL x0_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL x0_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [3:0] sels[6];
      sels[0] = 4'b0001; sels[1] = 4'b0010; sels[2] = 4'b0100;
      sels[3] = 4'b1000; sels[4] = 4'b0000; sels[5] = 4'b0110;
      clear_state();
      for (int c = 0; c < 800; c++) begin
         drive(($urandom_range(0, 3) != 0),
               mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), sels[$urandom_range(0, 5)]),
               4'($urandom), ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 49) == 0));
         rst_core = ($urandom_range(0, 199) == 0);
         settle();
         checks++;
         if (obs_flags !== exp_flags) begin
            failures++;
            $display("FAIL rand_flags c=%0d got=%b exp=%b", c, obs_flags, exp_flags);
         end
         checks++;
         if (out_data !== exp_data) begin
            failures++;
            $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, exp_data);
         end
         tick();
      end
      rst_core = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      test_reset();
      test_independent();
      test_dependent();
      test_backpressure();
      test_csr_serialize();
      test_flush();
      test_x0();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hsv_core_issue_scheduler.md
Name: hsv_core_issue_scheduler

Overview:
- Issue-stage scheduler. Sits between decode and the four exec-mem units (ALU, branch, memory, CSR).
- Holds one decoded `issue_data_t` entry and tracks in-flight destination registers in a scoreboard (`reg_mask`).
- Stalls on RAW/WAW hazards, then dispatches the entry to exactly one unit selected by the one-hot `exec_select`, using a valid/ready handshake per unit.
- Busy bits are cleared by commit writeback reports.

Parameters:
- SerializeCsr, 1, when 1 a CSR-selected entry dispatches only once the scoreboard is fully clear.

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  synchronous active-high reset
- flush  in  1  discard held entry and clear scoreboard
- in_valid  in  1  decode offers an entry
- in_ready  out  1  scheduler accepts the entry
- in_data  in  $bits(issue_data_t)  decoded entry
- out_data  out  $bits(issue_data_t)  held entry, shared by all units
- alu_valid / alu_ready  out / in  1 / 1  ALU handshake
- branch_valid / branch_ready  out / in  1 / 1  branch handshake
- mem_valid / mem_ready  out / in  1 / 1  memory handshake
- csr_valid / csr_ready  out / in  1 / 1  CSR handshake
- wb_valid  in  1  commit retires an instruction writing a register
- wb_rd  in  5 (reg_addr)  register being retired
- idle  out  1  no entry held and scoreboard empty

Behaviour:
- One clock, clk_core. Reset is synchronous, active-high, on rst_core.
- Reset state:
  - FSM = EMPTY; busy mask = 0; out_data = 0.
  - All *_valid = 0; in_ready = 0 while rst_core is high; idle = 1.
- FSM states:
  - EMPTY: no entry held.
  - STALL: entry held, hazard present.
  - SEND: entry held, unit valid asserted.
- Hazard definition:
  - hazard = busy[rs1] | busy[rs2] | busy[rd]. Any address of 0 contributes 0; x0 is never busy.
  - If SerializeCsr=1 and exec_select == SELECT_CSR, hazard also includes (busy mask != 0).
- Combinational transitions from the held entry:
  - STALL and SEND are combinational views of the held entry: hazard=1 → STALL, hazard=0 → SEND.
  - In SEND, exactly one *_valid is asserted, the one matching exec_select. A non-one-hot exec_select routes to ALU.
- Dispatch and acceptance:
  - Dispatch handshake = the selected valid & its ready, in the same cycle.
  - in_ready = !rst_core & !flush & (EMPTY | dispatch handshake). Throughput is 1 entry/cycle.
  - Accept (in_valid & in_ready): register in_data at the clock edge.
  - Minimum latency is 1 cycle: an entry accepted in cycle N can have valid high in cycle N+1.
- Data stability:
  - out_data and the selected valid stay stable while valid=1 and ready=0.
  - A unit must not see valid drop without a handshake, except on flush or reset.
- Scoreboard:
  - On dispatch with rd != 0: set busy[rd] at the clock edge.
  - On wb_valid with wb_rd != 0: clear busy[wb_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - wb_valid on a non-busy register: no effect.
  - rd = 0 means no writeback (stores, branches without link); the decoder guarantees this.
- Dependent back-to-back pair: an entry dependent on the previous dispatch's rd sees its busy bit the next cycle and stalls. No forwarding of same-cycle dispatch.
- Flush (priority over accept, dispatch and writeback):
  - Entry is dropped, FSM → EMPTY, busy mask → 0, all *_valid = 0 in the flush cycle.
  - Nothing is accepted in the flush cycle.
- idle = EMPTY & (busy mask == 0), registered-state based.
- Reset asserted mid-handshake: same effect as flush, plus in_ready = 0.

Optional Feature:
- Macro HSV_ISSUE_WB_BYPASS_EN.
- Defined: hazard evaluation uses the busy mask with the same-cycle writeback clear applied, i.e. busy & ~(wb_valid ? onehot(wb_rd) : 0). A stalled entry can dispatch in the same cycle its producer commits.
- Undefined: hazard uses the registered mask only. Dispatch occurs at the earliest one cycle after the wb_valid cycle.
- Scoreboard update rules are identical in both builds.

Test Plan:
- Independent ALU adds x1←x2,x3 then x4←x5,x6, alu_ready=1 → accepted on consecutive cycles, alu_valid high 2 consecutive cycles, busy = {x1,x4}.
- Dependent pair: x1←x2 then x3←x1 → second entry stalls (all valid=0) until wb_valid=1, wb_rd=1. It then dispatches the same cycle with bypass, or the next cycle without.
- Backpressure: mem entry with mem_ready=0 for 3 cycles → mem_valid held, out_data unchanged, in_ready=0. Ready=1 in cycle 4 → handshake, new entry accepted in the same cycle.
- CSR serialize: busy={x7}, CSR entry held → csr_valid=0 until x7 retires, then csr_valid=1. Only csr_valid, others 0.
- Flush while in SEND with busy={x1,x2} → next cycle: all valid=0, busy=0, idle=1. in_ready=0 during the flush cycle.
- x0 handling: entry rd=0, rs1=0 with wb_valid on rd 0 → dispatches with no stall, busy stays 0.
